// File: rtl/lc3_pkg.sv
// Shared constants for the LC-3 memory-mapped I/O block: register addresses,
// status bit positions, interrupt priority/vectors and the display-state enum.
package lc3_pkg;

    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;

    localparam int RDY_BIT = 15;
    localparam int IE_BIT  = 14;

    localparam logic [2:0] INT_PRIO = 3'd4;
    localparam logic [7:0] VEC_KB   = 8'h80;
    localparam logic [7:0] VEC_DS   = 8'h81;

    typedef enum logic {
        DISP_IDLE = 1'b0,
        DISP_BUSY = 1'b1
    } disp_state_e;

    // Status register image: ready in bit 15, interrupt enable in bit 14.
    function automatic logic [15:0] status_word(input logic rdy, input logic ie);
        return {rdy, ie, 14'b0};
    endfunction

endpackage

// File: rtl/lc3_disp_tx.sv
// Display transmitter: holds one character in ddr and offers it until the
// display consumes it; writes arriving while a character is pending are dropped.
module lc3_disp_tx
    import lc3_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_i,
    input  logic [7:0] wdata_i,
    input  logic       disp_ready_i,
    output logic       ds_rdy_o,
    output logic       disp_valid_o,
    output logic [7:0] disp_data_o
);

    disp_state_e state_q, state_d;
    logic [7:0]  ddr_q, ddr_d;

    // State and character register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DISP_IDLE;
            ddr_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            ddr_q   <= ddr_d;
        end
    end

    // Next-state logic; ddr only loads on the IDLE->BUSY transition.
    always_comb begin
        state_d = state_q;
        ddr_d   = ddr_q;
        case (state_q)
            DISP_IDLE: begin
                if (wr_i) begin
                    ddr_d   = wdata_i;
                    state_d = DISP_BUSY;
                end else begin
                    state_d = DISP_IDLE;
                end
            end
            DISP_BUSY: begin
                if (disp_ready_i) begin
                    state_d = DISP_IDLE;
                end else begin
                    state_d = DISP_BUSY;
                end
            end
            default: begin
                state_d = DISP_IDLE;
            end
        endcase
    end

    assign ds_rdy_o     = (state_q == DISP_IDLE);
    assign disp_valid_o = (state_q == DISP_BUSY);
    assign disp_data_o  = ddr_q;

endmodule

// File: rtl/lc3_mmio_ctrl.sv
// LC-3 memory-mapped I/O controller: keyboard receive register, display
// transmit register and a registered interrupt request/priority/vector encoder.
module lc3_mmio_ctrl
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] mmio_addr,
    input  logic [15:0] mmio_wdata,
    input  logic        mmio_load,
    input  logic        mmio_rd,
    output logic [15:0] mmio_rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        irq,
    output logic [2:0]  intp,
    output logic [7:0]  intv
);

    logic       kb_rdy_q, kb_rdy_d;
    logic       kb_ie_q, kb_ie_d;
    logic [7:0] kb_buf_q, kb_buf_d;
    logic       ds_ie_q, ds_ie_d;
    logic       irq_q, irq_d;
    logic [2:0] intp_q, intp_d;
    logic [7:0] intv_q, intv_d;

    logic       kb_accept_s, kbdr_rd_s, ddr_wr_s;
    logic       ds_rdy_s, kb_int_s, ds_int_s;
    logic       unused_wdata_s;

    assign kb_accept_s = kb_valid && !kb_rdy_q;
    assign kbdr_rd_s   = mmio_rd && (mmio_addr == ADDR_KBDR);
    assign ddr_wr_s    = mmio_load && (mmio_addr == ADDR_DDR);
    assign kb_int_s    = kb_rdy_q && kb_ie_q;
    assign ds_int_s    = ds_rdy_s && ds_ie_q;

    // Only the ie bit and the display character are ever taken from write data.
    assign unused_wdata_s = ^{mmio_wdata[15], mmio_wdata[13:8]};

    lc3_disp_tx u_disp_tx (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_i         (ddr_wr_s),
        .wdata_i      (mmio_wdata[7:0]),
        .disp_ready_i (disp_ready),
        .ds_rdy_o     (ds_rdy_s),
        .disp_valid_o (disp_valid),
        .disp_data_o  (disp_data)
    );

    // Keyboard and interrupt state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kb_rdy_q <= 1'b0;
            kb_ie_q  <= 1'b0;
            kb_buf_q <= 8'h00;
            ds_ie_q  <= 1'b0;
            irq_q    <= 1'b0;
            intp_q   <= 3'd0;
            intv_q   <= 8'h00;
        end else begin
            kb_rdy_q <= kb_rdy_d;
            kb_ie_q  <= kb_ie_d;
            kb_buf_q <= kb_buf_d;
            ds_ie_q  <= ds_ie_d;
            irq_q    <= irq_d;
            intp_q   <= intp_d;
            intv_q   <= intv_d;
        end
    end

    // Keyboard capture/clear and ie-bit writes. A capture can only happen
    // while kb_rdy is clear, so it never races a meaningful clear.
    always_comb begin
        kb_rdy_d = kb_rdy_q;
        kb_buf_d = kb_buf_q;
        kb_ie_d  = kb_ie_q;
        ds_ie_d  = ds_ie_q;
        if (kb_accept_s) begin
            kb_rdy_d = 1'b1;
            kb_buf_d = kb_data;
        end else if (kbdr_rd_s) begin
            kb_rdy_d = 1'b0;
        end else begin
            kb_rdy_d = kb_rdy_q;
        end
        if (mmio_load && (mmio_addr == ADDR_KBSR)) begin
            kb_ie_d = mmio_wdata[IE_BIT];
        end else begin
            kb_ie_d = kb_ie_q;
        end
        if (mmio_load && (mmio_addr == ADDR_DSR)) begin
            ds_ie_d = mmio_wdata[IE_BIT];
        end else begin
            ds_ie_d = ds_ie_q;
        end
    end

    // Interrupt encoder, keyboard has precedence over display.
    always_comb begin
        irq_d  = 1'b0;
        intp_d = 3'd0;
        intv_d = 8'h00;
        if (kb_int_s) begin
            irq_d  = 1'b1;
            intp_d = INT_PRIO;
            intv_d = VEC_KB;
        end else if (ds_int_s) begin
            irq_d  = 1'b1;
            intp_d = INT_PRIO;
            intv_d = VEC_DS;
        end else begin
            irq_d  = 1'b0;
            intp_d = 3'd0;
            intv_d = 8'h00;
        end
    end

    // Zero-latency read mux.
    always_comb begin
        mmio_rdata = 16'h0000;
        case (mmio_addr)
            ADDR_KBSR: mmio_rdata = status_word(kb_rdy_q, kb_ie_q);
            ADDR_KBDR: mmio_rdata = {8'h00, kb_buf_q};
            ADDR_DSR:  mmio_rdata = status_word(ds_rdy_s, ds_ie_q);
            ADDR_DDR:  mmio_rdata = {8'h00, disp_data};
            default:   mmio_rdata = 16'h0000;
        endcase
    end

    assign kb_ready = !kb_rdy_q;
    assign irq      = irq_q;
    assign intp     = intp_q;
    assign intv     = intv_q;

endmodule

// File: tb/tb_lc3_mmio_ctrl.sv
// Bench for lc3_mmio_ctrl: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the I/O registers.
module tb_lc3_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] mmio_addr = 16'h0000;
    logic [15:0] mmio_wdata = 16'h0000;
    logic        mmio_load = 1'b0;
    logic        mmio_rd = 1'b0;
    logic [15:0] mmio_rdata;
    logic        kb_valid = 1'b0;
    logic [7:0]  kb_data = 8'h00;
    logic        kb_ready;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready = 1'b0;
    logic        irq;
    logic [2:0]  intp;
    logic [7:0]  intv;

    int errors = 0;
    int checks = 0;

    // Reference model: what a program would observe through the register map.
    bit       m_kb_full;
    bit       m_kb_ie;
    bit [7:0] m_kb_char;
    bit       m_ds_ie;
    bit       m_disp_busy;
    bit [7:0] m_disp_char;
    bit       m_irq;
    bit [2:0] m_intp;
    bit [7:0] m_intv;
    bit [7:0] shown[$];

    lc3_mmio_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .mmio_load  (mmio_load),
        .mmio_rd    (mmio_rd),
        .mmio_rdata (mmio_rdata),
        .kb_valid   (kb_valid),
        .kb_data    (kb_data),
        .kb_ready   (kb_ready),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ready (disp_ready),
        .irq        (irq),
        .intp       (intp),
        .intv       (intv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [15:0] a);
        if (a == 16'hFE00) return m_kb_full ? (m_kb_ie ? 16'hC000 : 16'h8000) : (m_kb_ie ? 16'h4000 : 16'h0000);
        if (a == 16'hFE02) return 16'(m_kb_char);
        if (a == 16'hFE04) return !m_disp_busy ? (m_ds_ie ? 16'hC000 : 16'h8000) : (m_ds_ie ? 16'h4000 : 16'h0000);
        if (a == 16'hFE06) return 16'(m_disp_char);
        return 16'h0000;
    endfunction

    task automatic model_reset();
        m_kb_full = 1'b0; m_kb_ie = 1'b0; m_kb_char = 8'h00; m_ds_ie = 1'b0;
        m_disp_busy = 1'b0; m_disp_char = 8'h00;
        m_irq = 1'b0; m_intp = 3'd0; m_intv = 8'h00;
    endtask

    // Apply the current inputs to the model as one clock edge would.
    task automatic model_edge();
        bit kb_pending, ds_pending, was_busy;
        kb_pending = m_kb_full && m_kb_ie;
        ds_pending = !m_disp_busy && m_ds_ie;
        m_irq  = kb_pending || ds_pending;
        m_intp = m_irq ? 3'd4 : 3'd0;
        m_intv = kb_pending ? 8'h80 : (ds_pending ? 8'h81 : 8'h00);
        if (kb_valid && !m_kb_full) begin
            m_kb_full = 1'b1;
            m_kb_char = kb_data;
        end else if (mmio_rd && mmio_addr == 16'hFE02) begin
            m_kb_full = 1'b0;
        end
        was_busy = m_disp_busy;
        if (was_busy && disp_ready) begin
            m_disp_busy = 1'b0;
            shown.push_back(m_disp_char);
        end
        if (mmio_load) begin
            if (mmio_addr == 16'hFE00) m_kb_ie = mmio_wdata[14];
            if (mmio_addr == 16'hFE04) m_ds_ie = mmio_wdata[14];
            if (mmio_addr == 16'hFE06 && !was_busy) begin
                m_disp_busy = 1'b1;
                m_disp_char = mmio_wdata[7:0];
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mmio_load = 1'b0; mmio_rd = 1'b0; kb_valid = 1'b0; disp_ready = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".kb_ready"},   16'(kb_ready),   16'(!m_kb_full));
        chk({tag, ".disp_valid"}, 16'(disp_valid), 16'(m_disp_busy));
        chk({tag, ".disp_data"},  16'(disp_data),  16'(m_disp_char));
        chk({tag, ".irq"},        16'(irq),        16'(m_irq));
        chk({tag, ".intp"},       16'(intp),       16'(m_intp));
        chk({tag, ".intv"},       16'(intv),       16'(m_intv));
        chk({tag, ".rdata"},      mmio_rdata,      m_read(mmio_addr));
    endtask

    task automatic check_regs(input string tag);
        logic [15:0] save;
        save = mmio_addr;
        for (int i = 0; i < 4; i++) begin
            mmio_addr = 16'hFE00 + 16'(2 * i);
            #1;
            chk({tag, ".map"}, mmio_rdata, m_read(mmio_addr));
        end
        mmio_addr = save;
        #1;
    endtask

    initial begin
        model_reset();
        #12;
        mmio_addr = 16'hFE04;
        #1;
        chk("reset.dsr", mmio_rdata, 16'h8000);
        chk("reset.kb_ready", 16'(kb_ready), 16'h0001);
        chk("reset.disp_valid", 16'(disp_valid), 16'h0000);
        chk("reset.irq", {5'd0, intp, intv}, 16'h0000);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all("post_reset");
        check_regs("post_reset");

        // Keyboard receive.
        kb_valid = 1'b1; kb_data = 8'h41;
        tick();
        kb_valid = 1'b0; mmio_addr = 16'hFE00; #1;
        chk("kb_rx.kb_ready", 16'(kb_ready), 16'h0000);
        chk("kb_rx.kbsr", mmio_rdata, 16'h8000);
        mmio_addr = 16'hFE02; mmio_rd = 1'b1; #1;
        chk("kb_rx.kbdr", mmio_rdata, 16'h0041);
        tick();
        mmio_rd = 1'b0; mmio_addr = 16'hFE00; #1;
        chk("kb_rx.kbsr_clr", mmio_rdata, 16'h0000);

        // Keyboard backpressure.
        kb_valid = 1'b1; kb_data = 8'h41;
        tick();
        kb_data = 8'h42;
        tick(); tick();
        mmio_addr = 16'hFE02; #1;
        chk("kb_bp.kb_ready", 16'(kb_ready), 16'h0000);
        chk("kb_bp.kbdr_hold", mmio_rdata, 16'h0041);
        mmio_rd = 1'b1;
        tick();
        mmio_rd = 1'b0; #1;
        chk("kb_bp.kb_ready_clr", 16'(kb_ready), 16'h0001);
        tick();
        kb_valid = 1'b0; #1;
        chk("kb_bp.kbdr_new", mmio_rdata, 16'h0042);
        chk("kb_bp.kb_ready_full", 16'(kb_ready), 16'h0000);
        mmio_rd = 1'b1;
        tick();
        mmio_rd = 1'b0;
        check_all("kb_bp.end");

        // Display transfer.
        mmio_addr = 16'hFE06; mmio_wdata = 16'h0158; mmio_load = 1'b1;
        tick();
        mmio_wdata = 16'h005A;
        tick();
        mmio_load = 1'b0; mmio_addr = 16'hFE04; #1;
        chk("disp.valid", 16'(disp_valid), 16'h0001);
        chk("disp.data", 16'(disp_data), 16'h0058);
        chk("disp.dsr_busy", mmio_rdata, 16'h0000);
        disp_ready = 1'b1;
        tick();
        disp_ready = 1'b0; #1;
        chk("disp.dsr_done", mmio_rdata, 16'h8000);
        chk("disp.valid_done", 16'(disp_valid), 16'h0000);
        check_all("disp.end");

        // Interrupts.
        mmio_addr = 16'hFE00; mmio_wdata = 16'h4000; mmio_load = 1'b1;
        tick();
        mmio_load = 1'b0; kb_valid = 1'b1; kb_data = 8'h0D;
        tick();
        kb_valid = 1'b0; #1;
        chk("int.kbsr", mmio_rdata, 16'hC000);
        chk("int.irq_early", 16'(irq), 16'h0000);
        tick();
        chk("int.kb", {4'd0, irq, intp, intv}, {4'd0, 1'b1, 3'd4, 8'h80});
        mmio_addr = 16'hFE04; mmio_wdata = 16'h4000; mmio_load = 1'b1;
        tick();
        mmio_load = 1'b0;
        tick();
        chk("int.both", 16'(intv), 16'h0080);
        mmio_addr = 16'hFE02; mmio_rd = 1'b1;
        tick();
        mmio_rd = 1'b0;
        tick();
        chk("int.ds", {4'd0, irq, intp, intv}, {4'd0, 1'b1, 3'd4, 8'h81});
        mmio_addr = 16'hFE04; mmio_wdata = 16'h0000; mmio_load = 1'b1;
        tick();
        mmio_load = 1'b0;
        tick();
        chk("int.none", {4'd0, irq, intp, intv}, 16'h0000);

        // Unmapped address.
        mmio_addr = 16'hFE08; #1;
        chk("unmapped.read", mmio_rdata, 16'h0000);
        mmio_wdata = 16'hFFFF; mmio_load = 1'b1;
        tick();
        mmio_load = 1'b0;
        check_regs("unmapped");
        check_all("unmapped.end");

        // Reset while a character is being offered.
        mmio_addr = 16'hFE06; mmio_wdata = 16'h0077; mmio_load = 1'b1;
        tick();
        mmio_load = 1'b0; mmio_addr = 16'hFE04; #1;
        chk("rst_busy.valid_before", 16'(disp_valid), 16'h0001);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy.valid", 16'(disp_valid), 16'h0000);
        chk("rst_busy.dsr", mmio_rdata, 16'h8000);
        model_reset();
        @(posedge clk); #2;
        rst_n = 1'b1;
        shown.delete();
        disp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_busy.no_reoffer", 16'(disp_valid), 16'h0000);
        end
        disp_ready = 1'b0;
        check_all("rst_busy.end");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(5, 0))
                0: mmio_addr = 16'hFE00;
                1: mmio_addr = 16'hFE02;
                2: mmio_addr = 16'hFE04;
                3: mmio_addr = 16'hFE06;
                4: mmio_addr = 16'hFE08;
                default: mmio_addr = 16'($urandom);
            endcase
            mmio_wdata = 16'($urandom);
            mmio_load  = ($urandom_range(3, 0) == 0);
            mmio_rd    = ($urandom_range(2, 0) == 0);
            kb_valid   = ($urandom_range(1, 0) == 1);
            kb_data    = 8'($urandom);
            disp_ready = ($urandom_range(2, 0) != 0);
            #1;
            check_all("rand");
            tick();
        end
        idle_inputs();
        #1;
        check_all("rand.end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lc3_mmio_ctrl.md
LC3_MMIO_CTRL -- requirements
Module: lc3_mmio_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 mmio_addr  in  16  access address, driven by the datapath MAR.
REQ-005 mmio_wdata  in  16  write data, driven by the datapath MDR (MemoryMappedIO_out).
REQ-006 mmio_load  in  1  write strobe for one cycle (MemoryMappedIO_load).
REQ-007 mmio_rd  in  1  read strobe for one cycle, asserted in the cycle the MDR captures mmio_rdata.
REQ-008 mmio_rdata  out  16  read data to the datapath (MemoryMappedIO_in).
REQ-009 kb_valid / kb_data  in  1 / 8  keyboard character offer.
REQ-010 kb_ready  out  1  keyboard character accepted when kb_valid && kb_ready.
REQ-011 disp_valid / disp_data  out  1 / 8  display character offer.
REQ-012 disp_ready  in  1  display consumes the character when disp_valid && disp_ready.
REQ-013 irq / intp / intv  out  1 / 3 / 8  interrupt request, priority and vector to the datapath (IRQ, INTP, INTV).

Function
REQ-014 The register map SHALL be: KBSR x FE00, KBDR x FE02, DSR x FE04, DDR x FE06; any other address at or above x FE00 SHALL read x0000 and SHALL ignore writes.
REQ-015 mmio_rdata SHALL be combinational from mmio_addr with zero latency:
- KBSR = {kb_rdy, kb_ie, 14'b0}
- KBDR = {8'b0, kb_buf}
- DSR = {ds_rdy, ds_ie, 14'b0}
- DDR = {8'b0, ddr}
REQ-016 kb_ready SHALL equal !kb_rdy; on kb_valid && kb_ready, kb_buf SHALL take kb_data and kb_rdy SHALL set at the next edge.
REQ-017 mmio_rd at KBDR SHALL clear kb_rdy at the next edge; mmio_rd at any other address SHALL have no side effect.
REQ-018 A write to KBSR or DSR SHALL update only bit 14 (the ie bit); bit 15 SHALL be read-only.
REQ-019 Display FSM SHALL have two states, IDLE (ds_rdy=1, disp_valid=0) and BUSY (ds_rdy=0, disp_valid=1).
REQ-020 A write to DDR in IDLE SHALL latch mmio_wdata[7:0] into ddr and enter BUSY at the next edge.
REQ-021 A write to DDR in BUSY SHALL be ignored, with ddr unchanged.
REQ-022 BUSY with disp_ready=1 SHALL return to IDLE at the next edge; disp_data SHALL equal ddr and stay stable throughout BUSY.
REQ-023 If a DDR write and disp_ready coincide in BUSY, the block SHALL complete the transfer and SHALL drop the write.
REQ-024 Interrupt conditions SHALL be kb_int = kb_rdy && kb_ie and ds_int = ds_rdy && ds_ie.
REQ-025 irq SHALL be registered, asserting one cycle after either condition holds and deasserting one cycle after none holds.
REQ-026 When kb_int holds, intp/intv SHALL be 3'd4 / x80; otherwise, when ds_int holds, they SHALL be 3'd4 / x81; otherwise they SHALL be 0 / x00. The keyboard SHALL win when both hold.
REQ-027 intp and intv SHALL be registered alongside irq.

Reset
REQ-028 While rst_n=0 the block SHALL hold: kb_rdy=0, kb_ie=0, kb_buf=0, ds_ie=0, ddr=0, display FSM=IDLE (ds_rdy=1), irq=0, intp=0, intv=0.
REQ-029 During reset, kb_ready SHALL be 1 and disp_valid SHALL be 0.
REQ-030 Reset asserted mid-transfer SHALL abort the display character; the character SHALL not be re-offered.

Structure
REQ-031 The register addresses, bit positions (ready=15, ie=14), priority 3'd4 and vectors x80/x81 SHALL live in a shared package lc3_pkg, together with a display-state enum.
REQ-032 The display FSM SHALL be a sub-module lc3_disp_tx; the keyboard path and the interrupt encoder SHALL be inline.

Verification
REQ-033 Keyboard receive: kb_valid=1, kb_data=x41 for one cycle -> next cycle kb_ready=0 and KBSR read = x8000; KBDR read with mmio_rd -> rdata = x0041, next cycle KBSR = x0000.
REQ-034 Keyboard backpressure: kb_rdy=1 with kb_valid held at x42 -> kb_ready=0 and kb_buf stays x41 until the KBDR read; x42 is accepted one cycle after the clear.
REQ-035 Display: write DDR = x0158 -> next cycle disp_valid=1, disp_data=x58, DSR = x0000; second DDR write x005A while BUSY is ignored; disp_ready=1 -> next cycle DSR = x8000.
REQ-036 Interrupts: write KBSR = x4000, then accept char x0D -> irq=1, intp=4, intv=x80 one cycle after kb_rdy. With DSR ie also set, intv remains x80; after the KBDR read, intv becomes x81.
REQ-037 Unmapped address: read x FE08 -> x0000; write x FFFF to x FE08 -> no register changes.
REQ-038 Reset mid-BUSY: rst_n pulsed low while disp_valid=1 -> disp_valid=0 and DSR = x8000 immediately, with no re-offer after release.
